// File: rtl/lcd_data_buffer.sv
// Page buffer between image memory and the LCD controller: fetches 8 rows of 64 pixels,
// then streams 64 transposed column bytes, two clocks each. Option: LCD_BUF_INVERT_EN.
module lcd_data_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_request,
  input  logic [6:0]  addr,
  output logic        data_ack,
  output logic [7:0]  data,
  output logic        mem_rd,
  output logic [9:0]  mem_addr,
  input  logic [63:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACK    = 2'd2,
    STREAM = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [5:0]  byte_q, byte_d;
  logic        phase_q, phase_d;
  logic        ack_q, ack_d;
  logic [7:0]  data_q, data_d;
  logic        mem_rd_q, mem_rd_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [63:0] buf_q [0:7];
  logic [2:0]  row_wr_s;
  logic [5:0]  col_s;
  logic [7:0]  tbyte_s;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 7'd0;
      fcnt_q     <= 4'd0;
      byte_q     <= 6'd0;
      phase_q    <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= 8'd0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 10'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fcnt_q     <= fcnt_d;
      byte_q     <= byte_d;
      phase_q    <= phase_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Row captured in FETCH cycle n (fcnt_q = n-1) is the one read a cycle earlier
  assign row_wr_s = fcnt_q[2:0] - 3'd1;

  // Row buffer capture, deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == FETCH && fcnt_q != 4'd0) begin
      buf_q[row_wr_s] <= mem_data;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    byte_d  = byte_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        fcnt_d  = 4'd0;
        byte_d  = 6'd0;
        phase_d = 1'b0;
        if (data_request) begin
          addr_d  = addr;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!data_request) begin
          state_d = IDLE;
        end else if (fcnt_q == 4'd8) begin
          state_d = ACK;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      ACK: begin
        if (!data_request) begin
          state_d = STREAM;
        end else begin
          state_d = ACK;
        end
      end
      STREAM: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (byte_q == 6'd63) begin
            state_d = IDLE;
          end else begin
            byte_d = byte_q + 6'd1;
          end
        end else begin
          byte_d = byte_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic, evaluated on next state so the outputs are registered without extra latency
  always_comb begin
    col_s   = 6'd63 - byte_d;
    tbyte_s = 8'd0;
    for (int b = 0; b < 8; b++) begin
      tbyte_s[b] = buf_q[b][col_s];
    end
    mem_rd_d   = (state_d == FETCH) && (fcnt_d < 4'd8);
    mem_addr_d = mem_rd_d ? {addr_d, fcnt_d[2:0]} : 10'd0;
    ack_d      = (state_d == ACK);
    if (state_d == STREAM) begin
`ifdef LCD_BUF_INVERT_EN
      data_d = ~tbyte_s;
`else
      data_d = tbyte_s;
`endif
    end else begin
      data_d = 8'd0;
    end
  end

  assign data_ack = ack_q;
  assign data     = data_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_lcd_data_buffer.sv
// Self-checking bench for lcd_data_buffer: random image memory, page fetch/stream model,
// abort, reset and request-during-stream scenarios.
module tb_lcd_data_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_request;
  logic [6:0]  addr;
  logic        data_ack;
  logic [7:0]  data;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [63:0] mem_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] img [0:1023];

  always #5 clk = ~clk;

  lcd_data_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .data_request (data_request),
    .addr         (addr),
    .data_ack     (data_ack),
    .data         (data),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  // Image memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    mem_data <= mem_rd ? img[mem_addr] : {$urandom(), $urandom()};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Column byte k of page a: bit b is pixel (row b, column k)
  function automatic logic [7:0] exp_byte(input logic [6:0] a, input int k);
    logic [7:0]  r;
    logic [2:0]  row;
    logic [63:0] line;
    r = 8'd0;
    for (int b = 0; b < 8; b++) begin
      row  = b[2:0];
      line = img[{a, row}];
      r[b] = line[63 - k];
    end
`ifdef LCD_BUF_INVERT_EN
    r = ~r;
`endif
    return r;
  endfunction

  // Raise a request and follow the fetch; abort_at > 0 drops the request in that FETCH cycle
  task automatic fetch(input logic [6:0] a, input int abort_at, output bit acked);
    logic [9:0] seen [$];
    int n;
    bit got_ack;
    logic [2:0] r3;
    acked   = 1'b0;
    got_ack = 1'b0;
    @(negedge clk);
    data_request = 1'b1;
    addr = a;
    n = 0;
    while (n < 20 && !got_ack) begin
      @(negedge clk);
      n++;
      addr = 7'($urandom());
      check_eq("data_zero_fetch", {56'd0, data}, 64'd0);
      if (mem_rd) seen.push_back(mem_addr);
      else check_eq("mem_addr_idle", {54'd0, mem_addr}, 64'd0);
      if (data_ack) got_ack = 1'b1;
      if (!got_ack && abort_at > 0 && n == abort_at) begin
        data_request = 1'b0;
        @(negedge clk);
        check_eq("abort_mem_rd", {63'd0, mem_rd}, 64'd0);
        repeat (12) begin
          @(negedge clk);
          check_eq("abort_no_ack", {63'd0, data_ack}, 64'd0);
          check_eq("abort_no_rd", {63'd0, mem_rd}, 64'd0);
        end
        return;
      end
    end
    acked = got_ack;
    check_eq("ack_latency", 64'(n), 64'd10);
    check_eq("fetch_reads", 64'(seen.size()), 64'd8);
    for (int r = 0; r < 8 && r < seen.size(); r++) begin
      r3 = r[2:0];
      check_eq("fetch_addr", {54'd0, seen[r]}, {54'd0, a, r3});
    end
  endtask

  // Handshake and stream; rst_byte >= 0 resets while that byte is shown,
  // new_req >= 0 raises a request with that address in the middle of the stream
  task automatic stream(input logic [6:0] a, input int hold, input int rst_byte, input int new_req);
    repeat (hold) begin
      @(negedge clk);
      check_eq("ack_hold", {63'd0, data_ack}, 64'd1);
      check_eq("data_zero_ack", {56'd0, data}, 64'd0);
    end
    data_request = 1'b0;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      check_eq("stream_byte", {56'd0, data}, {56'd0, exp_byte(a, (i - 1) / 2)});
      check_eq("stream_ack_low", {63'd0, data_ack}, 64'd0);
      check_eq("stream_no_rd", {63'd0, mem_rd}, 64'd0);
      if (rst_byte >= 0 && i == 1 + 2 * rst_byte) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_data", {56'd0, data}, 64'd0);
        check_eq("rst_ack", {63'd0, data_ack}, 64'd0);
        repeat (4) begin
          @(negedge clk);
          check_eq("post_rst_data", {56'd0, data}, 64'd0);
        end
        return;
      end
      if (new_req >= 0 && i == 60) begin
        data_request = 1'b1;
        addr = 7'(new_req);
      end
    end
    @(negedge clk);
    check_eq("end_data_zero", {56'd0, data}, 64'd0);
    check_eq("end_no_rd", {63'd0, mem_rd}, 64'd0);
    check_eq("end_ack_low", {63'd0, data_ack}, 64'd0);
    if (new_req >= 0) begin
      @(negedge clk);
      check_eq("late_req_rd", {63'd0, mem_rd}, 64'd1);
      check_eq("late_req_addr", {54'd0, mem_addr}, {54'd0, 7'(new_req), 3'd0});
      data_request = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("late_req_abort", {63'd0, mem_rd}, 64'd0);
    end
  endtask

  initial begin
    bit acked;
    logic [6:0] a;
    logic [2:0] r3;
    rst = 1'b1;
    data_request = 1'b0;
    addr = 7'd0;
    for (int i = 0; i < 1024; i++) img[i] = {$urandom(), $urandom()};

    repeat (2) @(negedge clk);
    check_eq("reset_ack", {63'd0, data_ack}, 64'd0);
    check_eq("reset_data", {56'd0, data}, 64'd0);
    check_eq("reset_mem_rd", {63'd0, mem_rd}, 64'd0);
    check_eq("reset_mem_addr", {54'd0, mem_addr}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Diagonal image: byte k is a single set bit for k < 8
    for (int r = 0; r < 8; r++) begin
      r3 = r[2:0];
      img[{7'h2B, r3}] = 64'h8000_0000_0000_0000 >> r;
    end
    fetch(7'h2B, 0, acked);
    if (acked) stream(7'h2B, 1, -1, -1);

    // Abort at FETCH cycle 4, then a full refetch
    a = 7'h11;
    fetch(a, 4, acked);
    fetch(a, 0, acked);
    if (acked) stream(a, 0, -1, -1);

    // Reset at byte 20, then a full restart
    a = 7'h55;
    fetch(a, 0, acked);
    if (acked) stream(a, 2, 20, -1);
    fetch(a, 0, acked);
    if (acked) stream(a, 0, -1, -1);

    // Request during stream is serviced after it ends
    a = 7'h03;
    fetch(a, 0, acked);
    if (acked) stream(a, 1, -1, 'h6E);

    // All-zero page
    for (int r = 0; r < 8; r++) begin
      r3 = r[2:0];
      img[{7'h7F, r3}] = 64'd0;
    end
    fetch(7'h7F, 0, acked);
    if (acked) stream(7'h7F, 1, -1, -1);

    // Random pages and handshake lengths
    repeat (4) begin
      a = 7'($urandom());
      fetch(a, 0, acked);
      if (acked) stream(a, $urandom_range(0, 3), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_data_buffer.md
LCD_DATA_BUFFER -- requirements
Module: lcd_data_buffer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock, same clock as the LCD controller.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 data_request  input  1  page request from the LCD controller, level, held until data_ack is seen.
REQ-005 addr  input  7  page address {image[3:0], page[2:0]}, valid while data_request=1.
REQ-006 data_ack  output  1  page ready, stream start indicator.
REQ-007 data  output  8  LCD column byte; bit0 = top pixel row of the page.
REQ-008 mem_rd  output  1  image memory read strobe.
REQ-009 mem_addr  output  10  image memory row address {addr[6:0], row[2:0]}.
REQ-010 mem_data  input  64  image memory row; valid exactly 1 cycle after mem_rd; bit63 = column 0.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, ACK, STREAM.
REQ-012 IDLE: on data_request=1, latch addr, go to FETCH; otherwise stay in IDLE.
REQ-013 FETCH: assert mem_rd for 8 consecutive cycles with row 0..7; capture mem_data one cycle after each read into row buffer[row]; after row 7 is captured (cycle 9 of FETCH), go to ACK.
REQ-014 FETCH: if data_request falls before ACK, abort to IDLE with mem_rd=0 next cycle; buffer contents don't-care.
REQ-015 ACK: drive data_ack=1 while data_request=1; the first cycle with data_ack=1 and data_request=0 is T0; at the end of T0 drop data_ack and enter STREAM.
REQ-016 Transpose rule: byte k (k=0..63), bit b = buffer[b][63-k].
REQ-017 STREAM: byte k SHALL be stable on data during cycles T0+1+2k and T0+2+2k (two clocks per byte, matching the controller's half-rate sampling).
REQ-018 After cycle T0+128 the block SHALL return to IDLE with data=0.
REQ-019 data_request=1 during STREAM SHALL be ignored; it is serviced from IDLE the cycle after STREAM ends, if still asserted.
REQ-020 The byte counter SHALL be 6 bits with a separate 1-bit phase; no wrap-around past byte 63.
REQ-021 data SHALL be 0 in IDLE, FETCH and ACK.
REQ-022 addr changes while not in IDLE SHALL have no effect (latched copy used).
REQ-023 mem_addr SHALL be 0 whenever mem_rd=0.

Reset
REQ-024 On rst=1: state=IDLE, data_ack=0, data=0, mem_rd=0, mem_addr=0, counters=0; row buffer contents need not be cleared.
REQ-025 Reset asserted mid-FETCH or mid-STREAM SHALL abort immediately; the next request after reset starts a full fetch.
REQ-026 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-027 Macro LCD_BUF_INVERT_EN: when defined, data SHALL be the bitwise inverse of the transposed byte during STREAM (data stays 0 outside STREAM); when undefined, data is the transposed byte unmodified.

Verification
REQ-028 Reset then idle: rst=1 for 2 cycles -> data_ack=0, data=0, mem_rd=0, mem_addr=0.
REQ-029 Request addr=7'h2B, memory row r = 64'h8000_0000_0000_0000 >> r -> mem_addr 10'h158..10'h15F over 8 cycles, data_ack rises, and after handshake byte k = (k<8 ? 1<<k : 0).
REQ-030 Stream timing: drop data_request one cycle after data_ack -> byte 0 present at T0+1 and T0+2, byte 63 at T0+127/T0+128, data=0 and state IDLE at T0+129.
REQ-031 Abort: data_request drops at FETCH cycle 4 -> mem_rd=0 next cycle, data_ack never asserts, next request refetches all 8 rows.
REQ-032 Reset mid-STREAM at byte 20 -> data=0 next cycle, no further bytes, new request restarts at row 0.
REQ-033 With LCD_BUF_INVERT_EN defined, all-zero memory -> every streamed byte = 8'hFF, data=0 outside STREAM.
